// File: rtl/muldiv_scheduler.sv
// Multiply/divide sequencer owning HI/LO: fixed-latency busy window, ID stall request, EX cancel.
// Optional MULDIV_MADD_EN enables op 7 (signed multiply-accumulate into {hi,lo}).
module muldiv_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  op,
    input  logic        start,
    input  logic        cancel,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        md_instr_id,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   phi_q, phi_d, plo_q, plo_d;
    logic          pupd_q, pupd_d;

    logic               op_madd, op_div, start_op, go;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u, mac, res;
    logic               ovf;
    logic [31:0]        dvs, sq, sr, uq, ur;

    always_comb begin
`ifdef MULDIV_MADD_EN
        op_madd = (op == 3'd7);
`else
        op_madd = 1'b0;
`endif
        op_div   = (op == 3'd3) || (op == 3'd4);
        start_op = ((op >= 3'd1) && (op <= 3'd4)) || op_madd;
        go       = start && start_op && !cancel && (state_q == IDLE);
    end

    assign stall_req = md_instr_id & (busy_q | (start & start_op & ~cancel));

    // Divisor forced to 1 for /0 (result discarded) and for MIN/-1 (a/1 gives the required answer)
    always_comb begin
        prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
        prod_u = {32'b0, src_a} * {32'b0, src_b};
        mac    = {hi_q, lo_q} + $unsigned(prod_s);
        ovf    = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
        dvs    = ((src_b == 32'd0) || ovf) ? 32'd1 : src_b;
        sq     = $unsigned($signed(src_a) / $signed(dvs));
        sr     = $unsigned($signed(src_a) % $signed(dvs));
        uq     = src_a / ((src_b == 32'd0) ? 32'd1 : src_b);
        ur     = src_a % ((src_b == 32'd0) ? 32'd1 : src_b);
        case (op)
            3'd1:    res = $unsigned(prod_s);
            3'd2:    res = prod_u;
            3'd3:    res = {sr, sq};
            3'd4:    res = {ur, uq};
            default: res = mac;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        pupd_d  = pupd_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    phi_d   = res[63:32];
                    plo_d   = res[31:0];
                    pupd_d  = !(op_div && (src_b == 32'd0));
                    cnt_d   = op_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    state_d = BUSY;
                    busy_d  = 1'b1;
                end else if (!cancel && op == 3'd5) begin
                    hi_d = src_a;
                end else if (!cancel && op == 3'd6) begin
                    lo_d = src_a;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    if (pupd_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            pupd_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            pupd_q  <= pupd_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_scheduler.sv
// Bench for muldiv_scheduler: directed scenarios plus random traffic against an arithmetic reference model.
module tb_muldiv_scheduler;
    localparam int MULC = 5;
    localparam int DIVC = 10;
`ifdef MULDIV_MADD_EN
    localparam bit MADD = 1'b1;
`else
    localparam bit MADD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  op = '0;
    logic        start = 1'b0, cancel = 1'b0, md_instr_id = 1'b0;
    logic [31:0] src_a = '0, src_b = '0;
    logic        busy, stall_req;
    logic [31:0] hi, lo;

    muldiv_scheduler #(.MULT_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk(clk), .reset(reset), .op(op), .start(start), .cancel(cancel),
        .src_a(src_a), .src_b(src_b), .md_instr_id(md_instr_id),
        .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: remaining busy cycles, architectural HI/LO, result waiting to land
    int          m_rem = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    bit          p_upd = 1'b0;

    function automatic bit is_st(input logic [2:0] o);
        return ((o >= 3'd1) && (o <= 3'd4)) || (MADD && o == 3'd7);
    endfunction

    task automatic model_edge(input bit r, input logic [2:0] o, input bit st, input bit cn,
                              input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] v;
        v  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (r) begin
            m_rem = 0; m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_upd = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && p_upd) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (st && !cn && is_st(o)) begin
            p_upd = 1'b1;
            m_rem = (o == 3'd3 || o == 3'd4) ? DIVC : MULC;
            case (o)
                3'd1: v = 64'(sa * sb);
                3'd2: v = {32'b0, a} * {32'b0, b};
                3'd3: if (b == 0) p_upd = 1'b0; else v = {32'(sa % sb), 32'(sa / sb)};
                3'd4: if (b == 0) p_upd = 1'b0; else v = {a % b, a / b};
                default: v = {m_hi, m_lo} + 64'(sa * sb);
            endcase
            p_hi = v[63:32];
            p_lo = v[31:0];
        end else if (!cn && o == 3'd5) begin
            m_hi = a;
        end else if (!cn && o == 3'd6) begin
            m_lo = a;
        end
    endtask

    task automatic step(input bit r, input logic [2:0] o, input bit st, input bit cn,
                        input logic [31:0] a, input logic [31:0] b, input bit md);
        reset = r; op = o; start = st; cancel = cn; src_a = a; src_b = b; md_instr_id = md;
        #2;
        chk("stall_req", {63'b0, stall_req}, {63'b0, md && (m_rem > 0 || (st && !cn && is_st(o)))});
        @(posedge clk);
        model_edge(r, o, st, cn, a, b);
        #1;
        chk("busy", {63'b0, busy}, {63'b0, m_rem > 0});
        chk("hi", {32'b0, hi}, {32'b0, m_hi});
        chk("lo", {32'b0, lo}, {32'b0, m_lo});
    endtask

    task automatic idle(input bit md);
        step(1'b0, 3'd0, 1'b0, 1'b0, $urandom, $urandom, md);
    endtask

    // Counts busy cycles following a start step, bounded
    task automatic busy_len(input string tag, input int exp, input bit md);
        int n;
        n = 0;
        while (busy && n < 40) begin
            n++;
            idle(md);
        end
        chk(tag, 64'(n), 64'(exp));
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b;
        bit          st, cn, md;
        int          sel;

        step(1'b1, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b1, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);

        // mult -2*3 with ID stall held the whole way
        step(1'b0, 3'd1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3, 1'b1);
        busy_len("mult_busy_len", MULC, 1'b1);
        chk("mult_result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        idle(1'b1);

        step(1'b0, 3'd4, 1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
        busy_len("divu_busy_len", DIVC, 1'b0);
        chk("divu_result", {hi, lo}, {32'd2, 32'd14});

        step(1'b0, 3'd3, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1);
        busy_len("div_busy_len", DIVC, 1'b1);
        chk("div_result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        step(1'b0, 3'd1, 1'b1, 1'b1, 32'd5, 32'd6, 1'b1);
        chk("cancel_busy", {63'b0, busy}, 64'd0);
        chk("cancel_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        step(1'b0, 3'd6, 1'b0, 1'b1, 32'h1234, 32'd0, 1'b0);
        chk("mtlo_cancel", {32'b0, lo}, 64'hFFFF_FFFD);
        step(1'b0, 3'd5, 1'b0, 1'b0, 32'h5555, 32'd0, 1'b0);
        chk("mthi", {32'b0, hi}, 64'h5555);

        step(1'b0, 3'd3, 1'b1, 1'b0, 32'd77, 32'd0, 1'b1);
        busy_len("div0_busy_len", DIVC, 1'b1);
        chk("div0_hilo", {hi, lo}, 64'h0000_5555_FFFF_FFFD);

        step(1'b0, 3'd3, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        busy_len("ovf_busy_len", DIVC, 1'b0);
        chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

        // Reset landing on the third busy cycle of a div
        step(1'b0, 3'd5, 1'b0, 1'b0, 32'hAAAA, 32'd0, 1'b0);
        step(1'b0, 3'd3, 1'b1, 1'b0, 32'd50, 32'd3, 1'b0);
        idle(1'b0);
        idle(1'b0);
        step(1'b1, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("rst_mid_busy", {63'b0, busy}, 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        repeat (DIVC + 2) idle(1'b0);
        chk("rst_no_late", {hi, lo}, 64'd0);

        step(1'b0, 3'd5, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 3'd6, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
        step(1'b0, 3'd7, 1'b1, 1'b0, 32'd1, 32'd1, 1'b1);
        if (MADD) begin
            busy_len("madd_busy_len", MULC, 1'b0);
            chk("madd_result", {hi, lo}, 64'h0000_0001_0000_0000);
        end else begin
            chk("op7_busy", {63'b0, busy}, 64'd0);
            chk("op7_hilo", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
        end

        for (int i = 0; i < 400; i++) begin
            o   = 3'($urandom_range(7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(9);
            if (sel == 0) b = 0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) begin a = $urandom_range(200); b = $urandom_range(15); end
            cn = ($urandom_range(4) == 0);
            md = 1'($urandom_range(1));
            if (m_rem > 0) begin
                if (o == 3'd5 || o == 3'd6) o = 3'd0;
                st = 1'b0;
            end else begin
                st = (o >= 3'd1 && o <= 3'd4) || o == 3'd7;
            end
            step(1'b0, o, st, cn, a, b, md);
        end
        repeat (DIVC + 2) idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
